spram_bist: RTL and testbench
=============================

// Module: spram_bist
// PURPOSE
//  Self-test initiator for the 16Kx32 byte-addressable SPRAM target (sel/we/addr/wdat/rdat interface).
//  Runs three passes on command: FILL writes an LFSR pattern, MASK overwrites one byte lane per word,
//  and CHECK reads back and compares every word.
//  Reports pass/fail, an error count and the first failing byte address to the control/status logic.
//  Drives the RAM's ports directly; the RAM's 1-cycle registered read latency is the only timing assumed.
// PARAMETERS
//  WORDS   16384         number of 32-bit words tested (power of 2, 4..16384); sims use 16
//  SEED    32'h1234_5678 LFSR start value; 0 is replaced by 32'h0000_0001
// PORTS
//  clk        in   1   system clock; all logic rising-edge
//  rst        in   1   synchronous, active-high reset
//  start      in   1   1-cycle request to begin a test; ignored while busy=1
//  busy       out  1   high from the cycle after start is accepted until done
//  done       out  1   1-cycle pulse, test complete; pass/err_count/fail_addr valid from then until next start
//  pass       out  1   1 when err_count==0 at completion
//  err_count  out  16  mismatching words, saturates at 16'hFFFF
//  fail_addr  out  16  byte address of first mismatch (0 if none)
//  sel        out  1   RAM chip select
//  we         out  4   RAM byte write enables, we[n] -> bits [8n+7:8n]
//  addr       out  16  RAM byte address; addr[1:0] always 2'b00, word index in addr[15:2]
//  wdat       out  32  RAM write data
//  rdat       in   32  RAM read data, valid the cycle after a read (sel=1, we=0)
// BEHAVIOUR
//  - All outputs registered. Reset values: 0 for every output. rst is honoured in any state,
//    including mid-test; the next cycle is IDLE with sel=0, we=0, and results cleared.
//  - LFSR: 32-bit Galois, taps mask 32'h8020_0003, shifts once per word.
//    State = SEED at FILL start, and again at CHECK start.
//  - FSM states IDLE -> FILL -> MASK -> CHECK -> DRAIN -> IDLE. No other transitions except rst.
//    * IDLE: sel=0. start=1 clears err_count and fail_addr and loads the LFSR -> FILL. No other exit.
//    * FILL: word index i = 0..WORDS-1, one per cycle; sel=1, we=4'hF, wdat=lfsr, then step LFSR.
//      After i=WORDS-1 -> MASK.
//    * MASK: i = 0..WORDS-1; sel=1, we=4'b0001<<(i%4), wdat=32'hA5A5_A5A5.
//      After i=WORDS-1 -> CHECK (reload LFSR).
//    * CHECK: i = 0..WORDS-1; sel=1, we=0, wdat=0. Expected = lfsr with byte lane (i%4) replaced by 8'hA5.
//      Register expected and addr for the compare one cycle later; step LFSR.
//      After i=WORDS-1 -> DRAIN.
//    * DRAIN: sel=0; performs the final compare. Next cycle IDLE with done=1, busy=0.
//  - Compare (cycles CHECK+1 .. DRAIN): on rdat != expected, err_count+1 (saturating).
//    If this is the first error, fail_addr = registered address.
//  - Latency: start sampled high in cycle 0 -> FILL cycles 1..W, MASK W+1..2W, CHECK 2W+1..3W,
//    DRAIN 3W+1, done high in cycle 3W+2. busy is high in cycles 1..3W+1.
//  - pass = (err_count==0), registered with done, held until the next accepted start.
//  - start while busy: no effect on state, counters or outputs. start together with rst: rst wins.
//  - Word index wraps only via the state change; addr never exceeds (WORDS-1)*4.
//  - Only the low 16 bits of addr are meaningful; WORDS<16384 tests the low region only.
// TESTING (WORDS=16, behavioural 1-cycle-latency SPRAM model with per-byte write masks)
//  1 Clean run: start at cycle 0 -> busy 1..49, done pulse at cycle 50, pass=1, err_count=0, fail_addr=0.
//  2 Model XORs rdat[0] on read of word 5 -> err_count=1, fail_addr=16'h0014, pass=0.
//  3 Model ignores we mask (any we!=0 writes all lanes) -> every word mismatches: err_count=16,
//    fail_addr=16'h0000, pass=0.
//  4 Bus trace: MASK word 6 shows we=4'b0100, wdat=32'hA5A5A5A5, addr=16'h0018;
//    CHECK cycles show we=0, sel=1; addr[1:0]=0 throughout.
//  5 start pulsed at cycles 0 and 10 -> second pulse ignored, done still at cycle 50.
//    A new start after done gives identical results.
//  6 rst asserted at cycle 7 (mid-FILL) -> cycle 8: sel=0, we=0, busy=0, all outputs 0.
//    Restart -> clean pass per test 1.

Source files
------------

// File: rtl/spram_bist.sv
// spram_bist: self-test initiator for a byte-addressable 32-bit SPRAM.
// Runs FILL (LFSR pattern), MASK (one byte lane per word set to A5) and
// CHECK (read back and compare), then reports pass, error count and the
// byte address of the first mismatching word.
module spram_bist #(
  parameter int unsigned WORDS = 16384,
  parameter logic [31:0] SEED  = 32'h1234_5678
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [15:0] fail_addr,
  output logic        sel,
  output logic [3:0]  we,
  output logic [15:0] addr,
  output logic [31:0] wdat,
  input  logic [31:0] rdat
);

  localparam int unsigned    IW       = $clog2(WORDS);
  localparam logic [31:0]    SEED_EFF = (SEED == 32'h0000_0000) ? 32'h0000_0001 : SEED;
  localparam logic [IW-1:0]  LAST_IDX = IW'(WORDS - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_MASK  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  // One step of the 32-bit Galois LFSR (right shift, taps 8020_0003).
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    lfsr_step = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  // Replace byte lane 'lane' of v with 8'hA5.
  function automatic logic [31:0] lane_fill(input logic [31:0] v, input logic [1:0] lane);
    logic [31:0] m;
    m = 32'h0000_00FF << {lane, 3'b000};
    lane_fill = (v & ~m) | (32'hA5A5_A5A5 & m);
  endfunction

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [31:0]   lfsr_q, lfsr_d;
  logic [31:0]   lfsr_src;
  logic [31:0]   exp_q, exp_d;
  logic          cmp_valid_q, cmp_valid_d;
  logic [31:0]   cmp_exp_q, cmp_exp_d;
  logic [15:0]   cmp_addr_q, cmp_addr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic [15:0]   err_q, err_d;
  logic [15:0]   fail_q, fail_d;
  logic          sel_q, sel_d;
  logic [3:0]    we_q, we_d;
  logic [15:0]   addr_q, addr_d;
  logic [31:0]   wdat_q, wdat_d;

  // Sequencer, result accumulation and next bus transaction.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    lfsr_d      = lfsr_q;
    exp_d       = exp_q;
    cmp_valid_d = (state_q == ST_CHECK);
    cmp_exp_d   = exp_q;
    cmp_addr_d  = addr_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    err_d       = err_q;
    fail_d      = fail_q;
    sel_d       = 1'b0;
    we_d        = 4'h0;
    wdat_d      = 32'h0000_0000;

    // Compare the word read one cycle earlier.
    if (cmp_valid_q && (rdat != cmp_exp_q)) begin
      if (err_q == 16'h0000) begin
        fail_d = cmp_addr_q;
      end else begin
        fail_d = fail_q;
      end
      if (err_q != 16'hFFFF) begin
        err_d = err_q + 16'd1;
      end else begin
        err_d = err_q;
      end
    end else begin
      err_d = err_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FILL;
          idx_d   = '0;
          err_d   = 16'h0000;
          fail_d  = 16'h0000;
          pass_d  = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_MASK;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      ST_MASK: begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_CHECK;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      ST_CHECK: begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_DRAIN;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      ST_DRAIN: begin
        state_d = ST_IDLE;
        idx_d   = '0;
        done_d  = 1'b1;
        pass_d  = (err_d == 16'h0000);
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase

    // FILL and CHECK both begin the pattern at the seed.
    if ((state_q == ST_IDLE) || (state_q == ST_MASK)) begin
      lfsr_src = SEED_EFF;
    end else begin
      lfsr_src = lfsr_q;
    end

    case (state_d)
      ST_FILL: begin
        sel_d  = 1'b1;
        we_d   = 4'hF;
        wdat_d = lfsr_src;
        lfsr_d = lfsr_step(lfsr_src);
      end
      ST_MASK: begin
        sel_d  = 1'b1;
        we_d   = 4'b0001 << idx_d[1:0];
        wdat_d = 32'hA5A5_A5A5;
      end
      ST_CHECK: begin
        sel_d  = 1'b1;
        exp_d  = lane_fill(lfsr_src, idx_d[1:0]);
        lfsr_d = lfsr_step(lfsr_src);
      end
      default: begin
        sel_d = 1'b0;
      end
    endcase

    addr_d = 16'({idx_d, 2'b00});
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      lfsr_q      <= 32'h0000_0000;
      exp_q       <= 32'h0000_0000;
      cmp_valid_q <= 1'b0;
      cmp_exp_q   <= 32'h0000_0000;
      cmp_addr_q  <= 16'h0000;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= 16'h0000;
      fail_q      <= 16'h0000;
      sel_q       <= 1'b0;
      we_q        <= 4'h0;
      addr_q      <= 16'h0000;
      wdat_q      <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      lfsr_q      <= lfsr_d;
      exp_q       <= exp_d;
      cmp_valid_q <= cmp_valid_d;
      cmp_exp_q   <= cmp_exp_d;
      cmp_addr_q  <= cmp_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_q       <= err_d;
      fail_q      <= fail_d;
      sel_q       <= sel_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdat_q      <= wdat_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_addr = fail_q;
  assign sel       = sel_q;
  assign we        = we_q;
  assign addr      = addr_q;
  assign wdat      = wdat_q;

endmodule

// File: tb/tb_spram_bist.sv
// Bench for spram_bist (WORDS=16): SPRAM model with optional faults, a
// cycle-count reference model of the bus and results, directed scenarios
// and randomized start/reset/fault sequences.
module tb_spram_bist;

  localparam int W = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, pass, sel;
  logic [15:0] err_count, fail_addr, addr;
  logic [3:0]  we;
  logic [31:0] wdat;
  logic [31:0] rdat = 32'h0;

  int n_checks = 0;
  int n_fail   = 0;
  int fault_mode = 0;   // 0 clean, 1 flip bit0 of word 5 on read, 2 ignore byte mask
  bit chk_en = 1'b0;
  int t_rel = 0;

  spram_bist #(.WORDS(W), .SEED(32'h1234_5678)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_addr(fail_addr), .sel(sel), .we(we),
    .addr(addr), .wdat(wdat), .rdat(rdat)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- SPRAM model ----------------
  logic [31:0] mem [W];
  always @(posedge clk) begin
    if (sel) begin
      if (we != 4'h0) begin
        for (int b = 0; b < 4; b++) begin
          if (we[b] || fault_mode == 2) mem[addr[5:2]][8*b +: 8] <= wdat[8*b +: 8];
        end
      end else begin
        rdat <= mem[addr[5:2]] ^ ((fault_mode == 1 && addr[5:2] == 4'd5) ? 32'h1 : 32'h0);
      end
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] pat [W];
  int  mrel = 0;          // 0 = idle, k = k-th cycle after accepted start
  bit  mdone = 0;
  logic [15:0] mres_err = 0, mres_fail = 0, pend_err = 0, pend_fail = 0;
  bit  mres_pass = 0;

  initial begin
    logic [31:0] s;
    s = 32'h1234_5678;
    for (int i = 0; i < W; i++) begin
      pat[i] = s;
      s = (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
    end
  end

  task automatic predict(input int mode, output logic [15:0] e, output logic [15:0] f);
    logic [31:0] ideal, got;
    e = 0; f = 0;
    for (int i = 0; i < W; i++) begin
      ideal = pat[i];
      ideal[8*(i%4) +: 8] = 8'hA5;
      got = (mode == 2) ? 32'hA5A5_A5A5 : ideal;
      if (mode == 1 && i == 5) got[0] = ~got[0];
      if (got != ideal) begin
        if (e == 0) f = 16'(4*i);
        e++;
      end
    end
  endtask

  always @(posedge clk) begin
    mdone = 0;
    if (rst) begin
      mrel = 0; mres_err = 0; mres_fail = 0; mres_pass = 0;
    end else if (mrel == 0) begin
      if (start) begin
        mrel = 1; mres_err = 0; mres_fail = 0; mres_pass = 0;
        predict(fault_mode, pend_err, pend_fail);
      end
    end else if (mrel == 3*W+1) begin
      mrel = 0; mdone = 1;
      mres_err = pend_err; mres_fail = pend_fail; mres_pass = (pend_err == 0);
    end else begin
      mrel++;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic        e_sel;
    logic [3:0]  e_we;
    logic [15:0] e_addr;
    logic [31:0] e_wdat;
    int j;
    if (chk_en) begin
      e_sel = 0; e_we = 0; e_addr = 0; e_wdat = 0;
      if (mrel >= 1 && mrel <= W) begin
        j = mrel - 1; e_sel = 1; e_we = 4'hF; e_addr = 16'(4*j); e_wdat = pat[j];
      end else if (mrel > W && mrel <= 2*W) begin
        j = mrel - W - 1; e_sel = 1; e_we = 4'(1 << (j % 4)); e_addr = 16'(4*j);
        e_wdat = 32'hA5A5_A5A5;
      end else if (mrel > 2*W && mrel <= 3*W) begin
        j = mrel - 2*W - 1; e_sel = 1; e_addr = 16'(4*j);
      end
      check("busy", {31'b0, busy}, {31'b0, (mrel != 0)});
      check("done", {31'b0, done}, {31'b0, mdone});
      check("sel", {31'b0, sel}, {31'b0, e_sel});
      check("we", {28'b0, we}, {28'b0, e_we});
      check("addr", {16'b0, addr}, {16'b0, e_addr});
      check("wdat", wdat, e_wdat);
      if (mrel == 0) begin
        check("err_count", {16'b0, err_count}, {16'b0, mres_err});
        check("fail_addr", {16'b0, fail_addr}, {16'b0, mres_fail});
        check("pass", {31'b0, pass}, {31'b0, mres_pass});
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1; t_rel++;
  endtask

  task automatic start_pulse();
    start = 1'b1; t_rel = 0; tick(); start = 1'b0;
  endtask

  task automatic run_to(input int target);
    while (t_rel < target) tick();
  endtask

  task automatic wait_done(input string name);
    while (!done && t_rel < 200) tick();
    check(name, t_rel, 50);
  endtask

  task automatic check_results(input string name, input logic [15:0] e, input logic [15:0] f,
                               input logic p);
    check({name, "_err"}, {16'b0, err_count}, {16'b0, e});
    check({name, "_fail_addr"}, {16'b0, fail_addr}, {16'b0, f});
    check({name, "_pass"}, {31'b0, pass}, {31'b0, p});
  endtask

  logic [31:0] lits [4];
  int guard;
  int spur, rst_at;
  bit do_rst, collide, spur_en;

  initial begin
    lits[0] = 32'h1234_5678; lits[1] = 32'h091A_2B3C;
    lits[2] = 32'h048D_159E; lits[3] = 32'h0246_8ACF;

    rst = 1'b1; tick(); chk_en = 1'b1; tick(); tick(); rst = 1'b0; tick();
    check_results("reset", 16'h0, 16'h0, 1'b0);

    // Clean run, first LFSR words pinned.
    fault_mode = 0;
    start_pulse();
    for (int k = 1; k <= 4; k++) begin
      check("fill_wdat_lit", wdat, lits[k-1]);
      tick();
    end
    wait_done("clean_done_cycle");
    check_results("clean", 16'h0, 16'h0, 1'b1);

    // Bus trace: MASK word 6 and first CHECK cycle.
    start_pulse();
    run_to(W + 1 + 6);
    check("mask6_we", {28'b0, we}, 32'h4);
    check("mask6_wdat", wdat, 32'hA5A5_A5A5);
    check("mask6_addr", {16'b0, addr}, 32'h18);
    run_to(2*W + 1);
    check("check0_sel", {31'b0, sel}, 32'h1);
    check("check0_we", {28'b0, we}, 32'h0);
    wait_done("trace_done_cycle");

    // Single bit read fault on word 5.
    fault_mode = 1;
    start_pulse();
    wait_done("bitflip_done_cycle");
    check_results("bitflip", 16'h1, 16'h14, 1'b0);

    // RAM ignores byte mask.
    fault_mode = 2;
    start_pulse();
    wait_done("nomask_done_cycle");
    check_results("nomask", 16'd16, 16'h0, 1'b0);

    // Start while busy is ignored; rerun gives identical results.
    fault_mode = 0;
    start_pulse();
    run_to(10);
    start = 1'b1; tick(); start = 1'b0;
    wait_done("busy_start_done_cycle");
    check_results("busy_start", 16'h0, 16'h0, 1'b1);
    start_pulse();
    wait_done("rerun_done_cycle");
    check_results("rerun", 16'h0, 16'h0, 1'b1);

    // Reset mid-FILL, then restart.
    start_pulse();
    run_to(7);
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst_sel", {31'b0, sel}, 32'h0);
    check("rst_we", {28'b0, we}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_addr", {16'b0, addr}, 32'h0);
    check("rst_wdat", wdat, 32'h0);
    check_results("rst", 16'h0, 16'h0, 1'b0);
    start_pulse();
    wait_done("rst_restart_done_cycle");
    check_results("rst_restart", 16'h0, 16'h0, 1'b1);

    // Randomized sequences checked by the per-cycle compare.
    for (int it = 0; it < 25; it++) begin
      guard = 0;
      while (mrel != 0 && guard < 300) begin tick(); guard++; end
      if (guard >= 300) begin
        n_checks++; n_fail++;
        $display("FAIL idle_timeout: got busy expected idle");
      end
      repeat ($urandom_range(0, 4)) tick();
      fault_mode = $urandom_range(0, 2);
      do_rst  = ($urandom_range(0, 3) == 0);
      collide = ($urandom_range(0, 5) == 0);
      spur_en = ($urandom_range(0, 1) == 1);
      rst_at  = $urandom_range(1, 3*W+1);
      spur    = $urandom_range(1, 3*W);
      for (int c = 0; c <= 3*W + 3; c++) begin
        start = (c == 0) || (spur_en && c == spur);
        rst   = (do_rst && c == rst_at) || (collide && c == 0);
        tick();
      end
      start = 1'b0; rst = 1'b0;
      tick();
    end

    guard = 0;
    while (mrel != 0 && guard < 300) begin tick(); guard++; end
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
